// File: rtl/buzzer_scheduler.sv
// Shares one buzzer tone generator between key-click, countdown-warning and alarm requesters,
// turning request pulses into timed on/off enable patterns with fixed-priority preemption.
module buzzer_scheduler #(
   parameter int unsigned TICK_DIV         = 100000,
   parameter int unsigned CLICK_MS         = 20,
   parameter int unsigned WARN_ON_MS       = 150,
   parameter int unsigned WARN_OFF_MS      = 100,
   parameter int unsigned WARN_COUNT       = 3,
   parameter int unsigned ALARM_ON_MS      = 250,
   parameter int unsigned ALARM_OFF_MS     = 250,
   parameter int unsigned ALARM_MAX_BURSTS = 240
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       req_click,
   input  logic       req_warn,
   input  logic       req_alarm,
   input  logic       cancel,
   output logic       buzz_en,
   output logic [1:0] active_src,
   output logic       drop,
   output logic       timeout
);

   typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);

   state_e        state_q;
   logic [PW-1:0] presc_q;
   logic [15:0]   tick_cnt_q;
   logic [7:0]    bursts_left_q;

   logic [1:0]  req_pri;
   logic [1:0]  req_cnt;
   logic        any_req;
   logic        accept;
   logic        tick;
   logic        phase_done;
   logic [15:0] on_len;
   logic [15:0] off_len;
   logic [15:0] phase_len;
   logic [7:0]  burst_init;

   always_comb begin
      req_pri = 2'd0;
      if (req_alarm)     req_pri = 2'd3;
      else if (req_warn) req_pri = 2'd2;
      else if (req_click) req_pri = 2'd1;
      req_cnt = {1'b0, req_click} + {1'b0, req_warn} + {1'b0, req_alarm};
      any_req = (req_cnt != 2'd0);
      accept  = !cancel && (req_pri > active_src);

      on_len  = 16'd1;
      off_len = 16'd1;
      unique case (active_src)
         2'd1: on_len = 16'(CLICK_MS);
         2'd2: begin
            on_len  = 16'(WARN_ON_MS);
            off_len = 16'(WARN_OFF_MS);
         end
         2'd3: begin
            on_len  = 16'(ALARM_ON_MS);
            off_len = 16'(ALARM_OFF_MS);
         end
         default: ;
      endcase
      phase_len = (state_q == StOn) ? on_len : off_len;

      burst_init = 8'd1;
      if (req_pri == 2'd2)      burst_init = 8'(WARN_COUNT);
      else if (req_pri == 2'd3) burst_init = 8'(ALARM_MAX_BURSTS);

      tick       = (presc_q == PreMax);
      phase_done = tick && (tick_cnt_q == phase_len - 16'd1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= StIdle;
         presc_q       <= '0;
         tick_cnt_q    <= '0;
         bursts_left_q <= '0;
         buzz_en       <= 1'b0;
         active_src    <= 2'd0;
         drop          <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         // Lower-priority requests in the same cycle are dropped even when the top one is taken.
         drop    <= any_req && (!accept || (req_cnt > 2'd1));
         timeout <= 1'b0;
         if (cancel) begin
            state_q       <= StIdle;
            presc_q       <= '0;
            tick_cnt_q    <= '0;
            bursts_left_q <= '0;
            buzz_en       <= 1'b0;
            active_src    <= 2'd0;
         end else if (accept) begin
            state_q       <= StOn;
            presc_q       <= '0;
            tick_cnt_q    <= '0;
            bursts_left_q <= burst_init;
            buzz_en       <= 1'b1;
            active_src    <= req_pri;
         end else if (state_q != StIdle) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) tick_cnt_q <= phase_done ? 16'd0 : tick_cnt_q + 16'd1;
            if (phase_done) begin
               if (state_q == StOff) begin
                  state_q <= StOn;
                  buzz_en <= 1'b1;
               end else if (bursts_left_q == 8'd1) begin
                  state_q       <= StIdle;
                  bursts_left_q <= '0;
                  buzz_en       <= 1'b0;
                  active_src    <= 2'd0;
                  timeout       <= (active_src == 2'd3);
               end else begin
                  state_q       <= StOff;
                  bursts_left_q <= bursts_left_q - 8'd1;
                  buzz_en       <= 1'b0;
               end
            end
         end
      end
   end

endmodule
